sram_nr1w: RTL and testbench

Parametrised synchronous memory model with N read ports and one byte-masked write port. It succeeds the fixed 64K×128 two-read/one-write buffer used around `Top` for M1–M4. Read latency, depth, width, port count and read/write collision policy are configurable, and each read port has a registered valid pipeline. An optional post-reset clear engine zeroes the array, so picture-to-picture runs start from known contents.

---
 rtl/sram_nr1w_pkg.sv | 18 +
 rtl/sram_nr1w_rd_pipe.sv | 65 ++++++
 rtl/sram_nr1w.sv | 139 +++++++++++++
 tb/tb_sram_nr1w.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_nr1w_pkg.sv
// sram_pkg: shared defaults, limits and types for the sram_nr1w memory model.
//   DATA_W_DEF / ADDR_W_DEF / DEPTH_DEF : default geometry (64K x 128)
//   MAX_RD / MAX_LAT                    : supported read-port count / read latency
//   clr_state_t                         : clear-engine states (built with SRAM_NR1W_CLEAR_EN)
package sram_pkg;

   localparam int unsigned DATA_W_DEF = 128;
   localparam int unsigned ADDR_W_DEF = 16;
   localparam int unsigned DEPTH_DEF  = 65536;
   localparam int unsigned MAX_RD     = 4;
   localparam int unsigned MAX_LAT    = 3;

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } clr_state_t;

endpackage

// File: rtl/sram_nr1w_rd_pipe.sv
// sram_rd_pipe: one read port's RD_LAT-deep data/valid pipeline.
//   clock, reset_n : clock, synchronous active-low flush of all stages
//   req            : read request sampled this edge
//   raddr          : requested address (out-of-range returns zero data)
//   force_zero     : return zero data regardless of word (array being cleared)
//   word           : array word already resolved for collisions
//   rdata, rvalid  : output stage; rdata holds its last value when rvalid=0
module sram_rd_pipe
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req,
   input  logic [ADDR_W-1:0] raddr,
   input  logic              force_zero,
   input  logic [DATA_W-1:0] word,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic              oor;
   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [DATA_W-1:0] dat_q [RD_LAT];
   logic [DATA_W-1:0] dat_d [RD_LAT];

   // Each stage only captures data that is valid, so the last stage keeps
   // the most recent returned word while idle reads flow through.
   always_comb begin
      oor      = !({1'b0, raddr} < DEPTH_L);
      vld_d[0] = req;
      dat_d[0] = dat_q[0];
      if (req) begin
         dat_d[0] = (oor || force_zero) ? '0 : word;
      end
      for (int unsigned i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   assign rdata  = dat_q[RD_LAT-1];
   assign rvalid = vld_q[RD_LAT-1];

endmodule

// File: rtl/sram_nr1w.sv
// sram_nr1w: synchronous memory, N_RD read ports, one byte-masked write port.
//   clock, reset_n       : single clock, synchronous active-low reset
//   we/waddr/wdata/wbe   : write port; wbe[i] enables wdata[8i+7:8i]
//   re/raddr             : per-port read request, port p at raddr[p*ADDR_W +: ADDR_W]
//   rdata/rvalid         : per-port result after RD_LAT edges, port p at rdata[p*DATA_W +: DATA_W]
//   init_busy            : clear engine sweeping the array
// Build option: define SRAM_NR1W_CLEAR_EN to zero the array after every reset.
// The array is named mem for hierarchical preload and dump access.
module sram_nr1w
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned N_RD     = 2,
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned WR_FIRST = 1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      waddr,
   input  logic [DATA_W-1:0]      wdata,
   input  logic [DATA_W/8-1:0]    wbe,
   input  logic [N_RD-1:0]        re,
   input  logic [N_RD*ADDR_W-1:0] raddr,
   output logic [N_RD*DATA_W-1:0] rdata,
   output logic [N_RD-1:0]        rvalid,
   output logic                   init_busy
);

   localparam int unsigned     BYTES   = DATA_W / 8;
   localparam int unsigned     IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   logic              wr_ok;
   logic [IDX_W-1:0]  widx;
   logic [DATA_W-1:0] be_mask;
   logic [DATA_W-1:0] wr_word;
   logic              clearing;
   logic [IDX_W-1:0]  clr_idx;
   logic              rd_zero;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_widx;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_word [N_RD];

`ifdef SRAM_NR1W_CLEAR_EN
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   clr_state_t       state_q, state_d;
   logic [IDX_W-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clearing = 1'b0;
      if (state_q == S_CLEAR) begin
         clearing = 1'b1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == LAST_IDX) begin
            state_d = S_RUN;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= S_CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign init_busy = (state_q == S_CLEAR);
   assign clr_idx   = cnt_q;
   assign rd_zero   = init_busy;
`else
   assign init_busy = 1'b0;
   assign clearing  = 1'b0;
   assign clr_idx   = '0;
   assign rd_zero   = 1'b0;
`endif

   always_comb begin
      be_mask = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         be_mask[8*i +: 8] = {8{wbe[i]}};
      end
      widx    = waddr[IDX_W-1:0];
      wr_ok   = reset_n && we && !init_busy && ({1'b0, waddr} < DEPTH_L);
      wr_word = (mem[widx] & ~be_mask) | (wdata & be_mask);

      // Clear sweep and port writes never coexist: writes are blocked while busy.
      mem_we    = (reset_n && clearing) || wr_ok;
      mem_widx  = clearing ? clr_idx : widx;
      mem_wdata = clearing ? '0 : wr_word;
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_widx] <= mem_wdata;
      end
   end

   // Write-first bypass: a read of the address being written sees the merged word.
   always_comb begin
      for (int unsigned p = 0; p < N_RD; p++) begin
         rd_word[p] = mem[raddr[p*ADDR_W +: IDX_W]];
         if ((WR_FIRST != 0) && wr_ok && (raddr[p*ADDR_W +: ADDR_W] == waddr)) begin
            rd_word[p] = wr_word;
         end
      end
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      sram_rd_pipe #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .DEPTH  (DEPTH),
         .RD_LAT (RD_LAT)
      ) u_pipe (
         .clock      (clock),
         .reset_n    (reset_n),
         .req        (re[p]),
         .raddr      (raddr[p*ADDR_W +: ADDR_W]),
         .force_zero (rd_zero),
         .word       (rd_word[p]),
         .rdata      (rdata[p*DATA_W +: DATA_W]),
         .rvalid     (rvalid[p])
      );
   end

endmodule

// File: tb/tb_sram_nr1w.sv
// tb_sram_nr1w: two sram_nr1w instances (RD_LAT=1 write-first, RD_LAT=3
// read-first) driven by identical stimulus and compared every cycle against a
// word-array reference model with per-port expected-output queues.
module tb_sram_nr1w;

   localparam int DW    = 128;
   localparam int AW    = 11;
   localparam int DEPTH = 1024;
   localparam int NR    = 2;
   localparam int LAT_A = 1;
   localparam int LAT_B = 3;
   localparam int BYTES = DW / 8;
`ifdef SRAM_NR1W_CLEAR_EN
   localparam bit CLR_EN = 1'b1;
`else
   localparam bit CLR_EN = 1'b0;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic              reset_n;
   logic              we;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic [BYTES-1:0]  wbe;
   logic [NR-1:0]     re;
   logic [NR*AW-1:0]  raddr;
   logic [NR*DW-1:0]  rdata_a, rdata_b;
   logic [NR-1:0]     rvalid_a, rvalid_b;
   logic              busy_a, busy_b;

   sram_nr1w #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .N_RD(NR),
               .RD_LAT(LAT_A), .WR_FIRST(1)) u_a (
      .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a),
      .init_busy(busy_a));

   sram_nr1w #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .N_RD(NR),
               .RD_LAT(LAT_B), .WR_FIRST(0)) u_b (
      .clock(clock), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
      .wbe(wbe), .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b),
      .init_busy(busy_b));

   typedef struct packed {
      logic          v;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          qa [NR][$];
   ent_t          qb [NR][$];
   logic [DW-1:0] last_a [NR];
   logic [DW-1:0] last_b [NR];
   logic          exp_va [NR];
   logic          exp_vb [NR];
   logic [DW-1:0] mm [DEPTH];
   int            clr_left;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                           input logic [BYTES-1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < BYTES; b++) begin
         if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
      end
      return r;
   endfunction

   task automatic set_idle();
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      wbe   = '0;
      re    = '0;
      raddr = '0;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      int unsigned sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) return AW'($urandom_range(DEPTH, 2**AW - 1));
      if (sel < 5)  return AW'($urandom_range(0, 15));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   // One clock: model the edge from the current inputs, then check all outputs.
   task automatic cycle();
      logic [DW-1:0] base;
      logic [DW-1:0] word_a;
      logic [AW-1:0] ra;
      ent_t          e;
      bit            busy_pre;
      bit            wr_ok;
      busy_pre = (clr_left > 0);
      if (reset_n) begin
         wr_ok = we && !busy_pre && (int'(waddr) < DEPTH);
         for (int p = 0; p < NR; p++) begin
            ra   = raddr[p*AW +: AW];
            base = '0;
            if (int'(ra) < DEPTH && !busy_pre) base = mm[ra];
            word_a = base;
            if (wr_ok && ra == waddr) word_a = merge(base, wdata, wbe);
            qa[p].push_back(ent_t'{re[p], word_a});
            qb[p].push_back(ent_t'{re[p], base});
         end
         if (wr_ok) mm[waddr] = merge(mm[waddr], wdata, wbe);
         if (clr_left > 0) clr_left--;
      end
      @(posedge clock);
      #1;
      if (!reset_n) begin
         for (int p = 0; p < NR; p++) begin
            qa[p].delete();
            qb[p].delete();
            repeat (LAT_A - 1) qa[p].push_back(ent_t'{1'b0, {DW{1'b0}}});
            repeat (LAT_B - 1) qb[p].push_back(ent_t'{1'b0, {DW{1'b0}}});
            last_a[p] = '0;
            last_b[p] = '0;
            exp_va[p] = 1'b0;
            exp_vb[p] = 1'b0;
         end
         if (CLR_EN) begin
            clr_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) mm[i] = '0;
         end
      end else begin
         for (int p = 0; p < NR; p++) begin
            e = qa[p].pop_front();
            exp_va[p] = e.v;
            if (e.v) last_a[p] = e.d;
            e = qb[p].pop_front();
            exp_vb[p] = e.v;
            if (e.v) last_b[p] = e.d;
         end
      end
      for (int p = 0; p < NR; p++) begin
         check_eq($sformatf("a%0d_rvalid", p), DW'(rvalid_a[p]), DW'(exp_va[p]));
         check_eq($sformatf("a%0d_rdata", p), rdata_a[p*DW +: DW], last_a[p]);
         check_eq($sformatf("b%0d_rvalid", p), DW'(rvalid_b[p]), DW'(exp_vb[p]));
         check_eq($sformatf("b%0d_rdata", p), rdata_b[p*DW +: DW], last_b[p]);
      end
      check_eq("a_init_busy", DW'(busy_a), DW'(clr_left > 0));
      check_eq("b_init_busy", DW'(busy_b), DW'(clr_left > 0));
   endtask

   initial begin
      logic [DW-1:0] d0, d1;
      int            both_valid;

      clr_left = 0;
      set_idle();
      reset_n = 1'b0;
      repeat (3) cycle();
      check_eq("reset_rdata_a", rdata_a[0 +: DW], '0);
      check_eq("reset_rvalid_b", DW'(rvalid_b), '0);
      reset_n = 1'b1;

      // Fill every word (with the clear engine these land during the sweep and drop).
      for (int i = 0; i < DEPTH; i++) begin
         we    = 1'b1;
         waddr = AW'(i);
         wdata = rnd_word();
         wbe   = '1;
         cycle();
      end
      set_idle();
      repeat (4) cycle();

      // Byte-enable merge.
      we    = 1'b1;
      waddr = AW'(5);
      wdata = 128'h0F0E0D0C0B0A09080706050403020100;
      wbe   = '1;
      cycle();
      wdata = {16{8'hAA}};
      wbe   = 16'h0001;
      cycle();
      set_idle();
      re[0]          = 1'b1;
      raddr[0 +: AW] = AW'(5);
      cycle();
      check_eq("be_merge_data", rdata_a[0 +: DW], 128'h0F0E0D0C0B0A090807060504030201AA);
      check_eq("be_merge_valid", DW'(rvalid_a[0]), DW'(1));
      set_idle();
      cycle();

      // Collision on port 1 at address 9.
      d0 = rnd_word();
      d1 = ~d0;
      we    = 1'b1;
      waddr = AW'(9);
      wdata = d0;
      wbe   = '1;
      cycle();
      wdata           = d1;
      re[1]           = 1'b1;
      raddr[AW +: AW] = AW'(9);
      cycle();
      check_eq("collision_wr_first", rdata_a[DW +: DW], d1);
      we = 1'b0;
      cycle();
      check_eq("after_collision_a", rdata_a[DW +: DW], d1);
      set_idle();
      cycle();
      check_eq("collision_rd_first", rdata_b[DW +: DW], d0);
      cycle();
      check_eq("after_collision_b", rdata_b[DW +: DW], d1);
      repeat (3) cycle();

      // Back-to-back reads of 0..7 on both ports.
      both_valid = 0;
      for (int a = 0; a < 12; a++) begin
         set_idle();
         if (a < 8) begin
            re              = '1;
            raddr[0 +: AW]  = AW'(a);
            raddr[AW +: AW] = AW'(a);
         end
         cycle();
         if (rvalid_b == 2'b11) both_valid++;
      end
      check_eq("b2b_valid_cycles", DW'(both_valid), DW'(8));

      // Out-of-range write and read.
      set_idle();
      we    = 1'b1;
      waddr = AW'(DEPTH);
      wdata = rnd_word();
      wbe   = '1;
      cycle();
      set_idle();
      re              = 2'b11;
      raddr[0 +: AW]  = AW'(DEPTH);
      raddr[AW +: AW] = AW'(0);
      cycle();
      check_eq("oor_rdata", rdata_a[0 +: DW], '0);
      check_eq("oor_rvalid", DW'(rvalid_a[0]), DW'(1));
      set_idle();
      repeat (3) cycle();

      // Reset while reads are in flight.
      re              = 2'b11;
      raddr[0 +: AW]  = AW'(3);
      raddr[AW +: AW] = AW'(4);
      repeat (2) cycle();
      set_idle();
      reset_n = 1'b0;
      cycle();
      check_eq("midreset_rvalid_b", DW'(rvalid_b), '0);
      check_eq("midreset_rdata_b", rdata_b[0 +: DW], '0);
      reset_n = 1'b1;
      repeat (5) cycle();

      // Random traffic with collisions, out-of-range accesses and rare resets.
      repeat (3000) begin
         reset_n = ($urandom_range(0, 399) != 0);
         we      = 1'($urandom_range(0, 1));
         waddr   = rnd_addr();
         wdata   = rnd_word();
         wbe     = BYTES'($urandom);
         re      = NR'($urandom);
         for (int p = 0; p < NR; p++) raddr[p*AW +: AW] = rnd_addr();
         cycle();
      end
      reset_n = 1'b1;
      set_idle();
      repeat (4) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
